// File: rtl/timer_irq_ctrl_pkg.sv
// Shared constants, APB FSM state type and counter helper for timer_irq_ctrl.
// TIMER_IRQ_PULSE_EN (see timer_irq_ctrl.sv) selects pulse instead of level IRQ.
package timer_irq_ctrl_pkg;

    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned CNT_WIDTH = 8;

    localparam logic [1:0] IER_OFS    = 2'd0;
    localparam logic [1:0] ISR_OFS    = 2'd1;
    localparam logic [1:0] OVFCNT_OFS = 2'd2;
    localparam logic [1:0] UDFCNT_OFS = 2'd3;

    localparam int unsigned OVF_BIT = 0;
    localparam int unsigned UDF_BIT = 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/timer_irq_ctrl_irq_event_cnt.sv
// Rising-edge detector plus saturating occurrence counter for one timer event.
// A clear coinciding with an event leaves the count at 1.
module irq_event_cnt
    import timer_irq_ctrl_pkg::*;
(
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 tmr,
    input  logic                 clr,
    output logic                 evt,
    output logic [CNT_WIDTH-1:0] count
);

    logic                 prev_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    assign evt   = tmr & ~prev_q;
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end
        if (evt) begin
            count_d = sat_inc(count_d);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            prev_q  <= tmr;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer event interrupt controller: APB register slave, pending/enable bits, event counters.
// Define TIMER_IRQ_PULSE_EN to make IRQ a one-cycle pulse on a new enabled pending bit.
module timer_irq_ctrl
    import timer_irq_ctrl_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 8,
    parameter int unsigned            DATA_WIDTH  = 8,
    parameter int unsigned            WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 'h10
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic                  TMR_OVF,
    input  logic                  TMR_URF,
    output logic                  IRQ
);

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    apb_state_e            state_q;
    logic [2:0]            wait_q;
    logic                  pready_q;
    logic                  pslverr_q;

    logic [1:0]            ier_q;
    logic [1:0]            isr_q;
    logic [1:0]            isr_d;
    logic                  irq_q;

    logic [ADDR_WIDTH-1:0] addr_ofs;
    logic [1:0]            reg_sel;
    logic                  addr_ok;
    logic                  xfer_done;
    logic                  wr_commit;
    logic [7:0]            reg_rdata;

    logic                  ovf_evt;
    logic                  urf_evt;
    logic                  ovf_clr;
    logic                  urf_clr;
    logic [CNT_WIDTH-1:0]  ovf_cnt;
    logic [CNT_WIDTH-1:0]  urf_cnt;

    logic                  unused_wdata;

    // Offset arithmetic wraps, so addresses below BASE_ADDR fall outside the window too.
    assign addr_ofs  = PADDR - BASE_ADDR;
    assign reg_sel   = addr_ofs[1:0];
    assign addr_ok   = (addr_ofs < ADDR_WIDTH'(NUM_REGS));
    assign xfer_done = pready_q & PSEL & PENABLE;
    assign wr_commit = xfer_done & PWRITE & addr_ok;

    assign ovf_clr = wr_commit && (reg_sel == OVFCNT_OFS);
    assign urf_clr = wr_commit && (reg_sel == UDFCNT_OFS);

    assign unused_wdata = ^PWDATA[DATA_WIDTH-1:2];

    irq_event_cnt u_ovf_cnt (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .tmr    (TMR_OVF),
        .clr    (ovf_clr),
        .evt    (ovf_evt),
        .count  (ovf_cnt)
    );

    irq_event_cnt u_urf_cnt (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .tmr    (TMR_URF),
        .clr    (urf_clr),
        .evt    (urf_evt),
        .count  (urf_cnt)
    );

    // New events are OR-ed in after the W1C so a coincident set survives the clear.
    always_comb begin
        isr_d = isr_q;
        if (wr_commit && (reg_sel == ISR_OFS)) begin
            isr_d = isr_q & ~PWDATA[1:0];
        end
        isr_d[OVF_BIT] = isr_d[OVF_BIT] | ovf_evt;
        isr_d[UDF_BIT] = isr_d[UDF_BIT] | urf_evt;
    end

    always_comb begin
        reg_rdata = '0;
        unique case (reg_sel)
            IER_OFS:    reg_rdata = {6'b0, ier_q};
            ISR_OFS:    reg_rdata = {6'b0, isr_q};
            OVFCNT_OFS: reg_rdata = ovf_cnt;
            UDFCNT_OFS: reg_rdata = urf_cnt;
            default:    reg_rdata = '0;
        endcase
    end

    // FSM trails the bus by one cycle: SETUP is the first bus access cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (PSEL && !PENABLE) begin
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                    wait_q  <= WAIT_INIT;
                    if (WAIT_INIT == 3'd0) begin
                        pready_q  <= 1'b1;
                        pslverr_q <= ~addr_ok;
                    end
                end
                StAccess: begin
                    if (wait_q == 3'd0) begin
                        state_q <= (PSEL && !PENABLE) ? StSetup : StIdle;
                    end else if (!PSEL) begin
                        state_q <= StIdle;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                        if (wait_q == 3'd1) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= ~addr_ok;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef TIMER_IRQ_PULSE_EN
    logic [1:0] isr_prev_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            isr_prev_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            isr_prev_q <= isr_q;
            irq_q      <= |(isr_q & ~isr_prev_q & ier_q);
        end
    end
`else
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(isr_q & ier_q);
        end
    end
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ier_q <= '0;
            isr_q <= '0;
        end else begin
            if (wr_commit && (reg_sel == IER_OFS)) begin
                ier_q <= PWDATA[1:0];
            end
            isr_q <= isr_d;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign IRQ     = irq_q;
    assign PRDATA  = (pready_q && !pslverr_q && !PWRITE) ? DATA_WIDTH'(reg_rdata) : '0;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl with a cycle-level register model and per-cycle IRQ check.
module tb_timer_irq_ctrl;

    localparam int unsigned WS   = 2;
    localparam logic [7:0]  BASE = 8'h10;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic       TMR_OVF;
    logic       TMR_URF;
    logic       IRQ;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model state: register contents as software sees them.
    logic [1:0] m_ier = '0;
    logic [1:0] m_isr = '0;
    logic [1:0] m_isr_last = '0;
    int         m_ovf_cnt = 0;
    int         m_udf_cnt = 0;
    logic       m_prev_ovf = 1'b0;
    logic       m_prev_urf = 1'b0;
    logic       m_irq = 1'b0;
    bit         m_commit = 1'b0;
    logic [7:0] m_caddr;
    logic [7:0] m_cdata;

    timer_irq_ctrl #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .WAIT_STATES (WS),
        .BASE_ADDR   (BASE)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .TMR_OVF (TMR_OVF),
        .TMR_URF (TMR_URF),
        .IRQ     (IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_reg(input logic [7:0] a);
        logic [7:0] ofs;
        ofs = a - BASE;
        case (ofs)
            8'd0:    return {6'b0, m_ier};
            8'd1:    return {6'b0, m_isr};
            8'd2:    return 8'(m_ovf_cnt);
            8'd3:    return 8'(m_udf_cnt);
            default: return 8'h00;
        endcase
    endfunction

    // Model: advances once per clock edge from the bench's own stimulus.
    initial begin
        logic       ovf_ev;
        logic       urf_ev;
        logic [1:0] isr_n;
        logic [1:0] ier_n;
        bit         clr_o;
        bit         clr_u;
        forever begin
            @(posedge PCLK);
            if (PRESET === 1'b1) begin
                m_ier = '0; m_isr = '0; m_isr_last = '0;
                m_ovf_cnt = 0; m_udf_cnt = 0;
                m_prev_ovf = 1'b0; m_prev_urf = 1'b0;
                m_irq = 1'b0; m_commit = 1'b0;
            end else begin
                ovf_ev = TMR_OVF && !m_prev_ovf;
                urf_ev = TMR_URF && !m_prev_urf;
`ifdef TIMER_IRQ_PULSE_EN
                m_irq = |(m_isr & ~m_isr_last & m_ier);
`else
                m_irq = |(m_isr & m_ier);
`endif
                m_isr_last = m_isr;
                isr_n = m_isr;
                ier_n = m_ier;
                clr_o = 1'b0;
                clr_u = 1'b0;
                if (m_commit) begin
                    case (8'(m_caddr - BASE))
                        8'd0: ier_n = m_cdata[1:0];
                        8'd1: isr_n = isr_n & ~m_cdata[1:0];
                        8'd2: clr_o = 1'b1;
                        8'd3: clr_u = 1'b1;
                        default: ;
                    endcase
                    m_commit = 1'b0;
                end
                isr_n = isr_n | {urf_ev, ovf_ev};
                if (clr_o) m_ovf_cnt = 0;
                if (clr_u) m_udf_cnt = 0;
                if (ovf_ev && m_ovf_cnt < 255) m_ovf_cnt++;
                if (urf_ev && m_udf_cnt < 255) m_udf_cnt++;
                m_isr = isr_n;
                m_ier = ier_n;
                m_prev_ovf = TMR_OVF;
                m_prev_urf = TMR_URF;
            end
        end
    end

    // Every cycle: IRQ follows the model, idle bus outputs stay quiet.
    initial begin
        forever begin
            @(negedge PCLK);
            if (check_en) begin
                check("irq_vs_model", IRQ, m_irq);
                if (PREADY !== 1'b1) begin
                    check("prdata_idle", PRDATA, 8'h00);
                    check("pslverr_idle", PSLVERR, 1'b0);
                end
            end
        end
    end

    // Starts #1 after a rising edge and returns #1 after the edge that ends the transfer.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            input bit ovf_at_ready, output logic [7:0] rdata,
                            output logic err);
        bit valid;
        valid   = (addr >= BASE) && (addr <= BASE + 8'd3);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        rdata   = 'x;
        err     = 'x;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        // One cycle for the SETUP state, WS wait cycles, then the ready cycle.
        for (int n = 1; n <= WS + 2; n++) begin
            if (n > 1) begin
                @(posedge PCLK);
                #1;
            end
            if (n == WS + 2 && ovf_at_ready) TMR_OVF = 1'b1;
            @(negedge PCLK);
            check("pready_timing", PREADY, (n == WS + 2));
            if (n == WS + 2) begin
                check("pslverr", PSLVERR, !valid);
                if (!wr) check("prdata", PRDATA, valid ? model_reg(addr) : 8'h00);
                rdata = PRDATA;
                err   = PSLVERR;
                if (wr && valid) begin
                    m_commit = 1'b1;
                    m_caddr  = addr;
                    m_cdata  = wdata;
                end
            end
        end
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] rd;
        logic       e;
        apb_xfer(1'b1, addr, data, 1'b0, rd, e);
    endtask

    task automatic rd_expect(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] rd;
        logic       e;
        apb_xfer(1'b0, addr, 8'h00, 1'b0, rd, e);
        check(name, rd, exp);
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        logic [7:0] rd;
        logic       e;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; TMR_OVF = 1'b0; TMR_URF = 1'b0;
        repeat (3) step();
        @(negedge PCLK);
        check("rst_pready", PREADY, 1'b0);
        check("rst_pslverr", PSLVERR, 1'b0);
        check("rst_prdata", PRDATA, 8'h00);
        check("rst_irq", IRQ, 1'b0);
        step();
        PRESET   = 1'b0;
        check_en = 1'b1;

        // Reset values.
        rd_expect("rst_ier", BASE + 8'd0, 8'h00);
        rd_expect("rst_isr", BASE + 8'd1, 8'h00);
        rd_expect("rst_ovfcnt", BASE + 8'd2, 8'h00);
        rd_expect("rst_udfcnt", BASE + 8'd3, 8'h00);

        // OVF event raises IRQ two cycles after the edge; W1C drops it.
        wr(BASE + 8'd0, 8'h03);
        rd_expect("ier_rb", BASE + 8'd0, 8'h03);
        TMR_OVF = 1'b1;
        @(negedge PCLK); check("irq_edge_c0", IRQ, 1'b0);
        step();
        @(negedge PCLK); check("irq_edge_c1", IRQ, 1'b0);
        step();
        @(negedge PCLK); check("irq_edge_c2", IRQ, 1'b1);
        step();
        TMR_OVF = 1'b0;
        rd_expect("isr_ovf", BASE + 8'd1, 8'h01);
        rd_expect("ovfcnt_1", BASE + 8'd2, 8'h01);
        wr(BASE + 8'd1, 8'h01);
`ifndef TIMER_IRQ_PULSE_EN
        @(negedge PCLK); check("irq_clr_c0", IRQ, 1'b1);
        step();
        @(negedge PCLK); check("irq_clr_c1", IRQ, 1'b0);
        step();
`endif
        rd_expect("isr_cleared", BASE + 8'd1, 8'h00);

        // 300 URF pulses saturate the counter.
        for (int i = 0; i < 300; i++) begin
            TMR_URF = 1'b1;
            step();
            TMR_URF = 1'b0;
            step();
        end
        rd_expect("udfcnt_sat", BASE + 8'd3, 8'hFF);
        rd_expect("isr_udf", BASE + 8'd1, 8'h02);
        wr(BASE + 8'd3, 8'h5A);
        rd_expect("udfcnt_clr", BASE + 8'd3, 8'h00);

        // Set beats a coincident W1C; event beats a coincident counter clear.
        wr(BASE + 8'd1, 8'hFF);
        rd_expect("isr_all_clr", BASE + 8'd1, 8'h00);
        apb_xfer(1'b1, BASE + 8'd1, 8'h01, 1'b1, rd, e);
        TMR_OVF = 1'b0;
        rd_expect("isr_set_wins", BASE + 8'd1, 8'h01);
        rd_expect("ovfcnt_2", BASE + 8'd2, 8'h02);
        apb_xfer(1'b1, BASE + 8'd2, 8'h00, 1'b1, rd, e);
        TMR_OVF = 1'b0;
        rd_expect("ovfcnt_clr_evt", BASE + 8'd2, 8'h01);

        // Unmapped addresses: error, no effect, read data zero.
        apb_xfer(1'b1, BASE + 8'd7, 8'hAA, 1'b0, rd, e);
        check("err_wr_slverr", e, 1'b1);
        apb_xfer(1'b0, 8'h05, 8'h00, 1'b0, rd, e);
        check("err_rd_slverr", e, 1'b1);
        check("err_rd_data", rd, 8'h00);
        apb_xfer(1'b0, BASE + 8'd4, 8'h00, 1'b0, rd, e);
        check("err_top_edge", e, 1'b1);
        apb_xfer(1'b0, BASE - 8'd1, 8'h00, 1'b0, rd, e);
        check("err_low_edge", e, 1'b1);
        rd_expect("ier_unchanged", BASE + 8'd0, 8'h03);
        rd_expect("isr_unchanged", BASE + 8'd1, 8'h01);

        // Reset during a write's access phase aborts it.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = BASE; PWDATA = 8'h03;
        step();
        PENABLE = 1'b1;
        step();
        PRESET = 1'b1;
        step();
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check("midrst_irq", IRQ, 1'b0);
        check("midrst_pready", PREADY, 1'b0);
        step();
        rd_expect("midrst_ier", BASE + 8'd0, 8'h00);
        rd_expect("midrst_isr", BASE + 8'd1, 8'h00);
        wr(BASE + 8'd0, 8'h03);
        rd_expect("post_rst_ier", BASE + 8'd0, 8'h03);

        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Downstream consumer of the timer's TMR_OVF / TMR_URF event outputs.
- Edge-detects both events, latches them into a pending register, counts occurrences, and drives a single level interrupt line to the CPU.
- Software access is through its own APB slave, on the same PCLK domain as the timer. It supports configurable wait states and returns PSLVERR on unmapped addresses.

Parameters:
- ADDR_WIDTH, 8, APB address width.
- DATA_WIDTH, 8, APB data width; register fields below assume 8.
- WAIT_STATES, 0, number of PREADY-low cycles inserted in every access phase (0..7).
- BASE_ADDR, 8'h10, address of the first register; the four registers occupy BASE_ADDR+0..+3.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  APB address.
- PWDATA  in  DATA_WIDTH  APB write data.
- PRDATA  out  DATA_WIDTH  read data; valid while PREADY=1 in the access phase; 0 otherwise.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error; only asserted together with PREADY.
- TMR_OVF  in  1  timer overflow flag (level).
- TMR_URF  in  1  timer underflow flag (level).
- IRQ  out  1  interrupt request to CPU.

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - All registers clear to 0: IER, ISR, OVF_CNT, UDF_CNT, edge-detect flops, FSM = IDLE.
  - Outputs: PRDATA=0, PREADY=0, PSLVERR=0, IRQ=0.
  - Reset mid-transfer aborts the transfer; no register is written.
- Register map (offset from BASE_ADDR):
  - +0 IER, RW. Bit0 = OVF enable, bit1 = UDF enable, bits 7:2 read 0.
  - +1 ISR, RW1C. Bit0 = OVF pending, bit1 = UDF pending.
  - +2 OVF_CNT, RO, saturating count of OVF events. Write = clear to 0.
  - +3 UDF_CNT, same as OVF_CNT, for UDF events.
- Event capture:
  - prev_ovf / prev_urf are registered each cycle.
  - An event is a rising edge: TMR_x=1 and prev_x=0.
  - On an event the ISR bit is set next cycle and the counter increments next cycle, saturating at 8'hFF.
  - A level held high counts once.
- Simultaneous events and writes:
  - Event in the same cycle as a W1C of that bit: set wins, bit stays 1.
  - Event in the same cycle as a counter-clear write: counter becomes 1.
- IRQ:
  - IRQ is registered: IRQ <= |(ISR & IER[1:0]), using the ISR value after update.
  - Latency is 2 cycles from the TMR edge to IRQ high, and 1 cycle from the ISR/IER write commit.
- APB FSM (IDLE, SETUP, ACCESS):
  - IDLE -> SETUP when PSEL=1, PENABLE=0.
  - SETUP -> ACCESS unconditionally, loading wait_cnt=WAIT_STATES.
  - In ACCESS: PREADY=0 while wait_cnt!=0 (decrement each cycle). At wait_cnt==0, PREADY=1 for exactly one cycle.
  - After the PREADY cycle: if PSEL=1 and PENABLE=0, go to SETUP (back-to-back transfer); else go to IDLE.
  - PENABLE=1 seen in IDLE (missing setup phase) is ignored; stay in IDLE.
  - If PSEL drops during ACCESS, return to IDLE with no commit.
- Commit and read data:
  - Writes commit on the PREADY cycle only.
  - PRDATA is driven on the PREADY cycle from the current register value.
- Invalid address (outside BASE_ADDR..+3):
  - PSLVERR=1 with PREADY.
  - Writes are discarded; reads return 0.
  - Wait states still apply.

Optional Feature:
- Macro: TIMER_IRQ_PULSE_EN.
- Defined: IRQ is a one-cycle pulse, produced on the cycle after any enabled ISR bit transitions 0->1. Reasserting an already-pending bit produces no new pulse.
- Undefined: IRQ is the level behaviour described above.

Decomposition:
- Shared package/include holds:
  - register offset constants IER_OFS=0, ISR_OFS=1, OVFCNT_OFS=2, UDFCNT_OFS=3;
  - bit indices OVF_BIT=0, UDF_BIT=1;
  - FSM state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2).
- One natural sub-module: irq_event_cnt. It is instantiated twice (one per event), and provides edge detect plus saturating counter with a clear input. The APB FSM and registers stay in the top module.

Test Plan:
- Reset then read all four registers -> each returns 8'h00, PSLVERR=0. With WAIT_STATES=2, PREADY is low for exactly 2 access cycles.
- Write IER=8'h03; pulse TMR_OVF high for 3 cycles -> ISR=8'h01, OVF_CNT=1, IRQ high 2 cycles after the edge. Write ISR=8'h01 -> IRQ low 1 cycle after commit.
- 300 separate TMR_URF pulses -> UDF_CNT=8'hFF (saturated). Write +3 -> reads 8'h00.
- W1C of ISR bit0 committed in the same cycle as a TMR_OVF rising edge -> ISR bit0 reads 1.
- Write 8'hAA to BASE_ADDR+7 and read 8'h05 -> PSLVERR=1 on both, PRDATA=0, no register changes.
- Assert PRESET during the ACCESS phase of a write IER=8'h03 -> IER=0, IRQ=0, FSM back in IDLE. The next transfer completes normally.
